// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone peripheral bridge.
//   bridge_state_e   : bridge FSM states
//   ERR_DATA_DEFAULT : read data handed back to the core when an access fails
package wb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        ERROR  = 3'd2,
        RESP   = 3'd3,
        GAP    = 3'd4
    } bridge_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Access watchdog for the bridge: counts cycles spent waiting on a slave.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count back to 0 (held while not waiting)
//   enable     : count one cycle
//   expired    : high during the LIMIT-th enabled cycle since the last clear
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Flags the last permitted wait cycle, so the owner leaves at the edge that
    // ends the LIMIT-th cycle of waiting.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_periph_bridge.sv
// Wishbone core-to-peripheral bridge. Decodes a slot from the request address,
// strobes one slave, and returns its data, or ERR_DATA with a sticky error
// flag for unmapped slots and slaves that never acknowledge.
//   clk, rst_n            : clock, synchronous active-low reset
//   cyc_i/stb_i/we_i      : core bus cycle, strobe, write
//   addr_i/data_i         : core address / write data
//   ack_o/data_o          : one-cycle completion pulse and read data to core
//   s_cyc_o/s_stb_o       : one-hot slave cycle/strobe
//   s_we_o/s_addr_o/s_data_o : latched request fields shared by all slaves
//   s_ack_i/s_data_i      : per-slot acks and packed read data
//   err_clr_i/err_o       : error clear, sticky error flag
//   err_addr_o            : address of the most recent failed access
//
// state  | meaning
// IDLE   | waiting for a request with addr_i[31]=1
// ACCESS | selected slave strobed, waiting for its ack or the timeout
// ERROR  | unmapped slot, one cycle to post the error
// RESP   | ack_o high for this one cycle
// GAP    | one dead cycle so a lingering core cyc_i is not taken as new
module wb_periph_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 24,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              data_i,
    output logic                     ack_o,
    output logic [31:0]              data_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_data_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES*32-1:0] s_data_i,
    input  logic                     err_clr_i,
    output logic                     err_o,
    output logic [31:0]              err_addr_o
);

    bridge_state_e state_q, state_d;

    logic [3:0]            slot_q, slot_d;
    logic                  ack_q, ack_d;
    logic [31:0]           data_q, data_d;
    logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic [3:0]            slot_in;
    logic                  slot_in_range;
    logic [NUM_SLAVES-1:0] onehot_in;
    logic                  ack_sel;
    logic [31:0]           rd_sel;
    logic                  expired;
    logic                  err_set;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != ACCESS),
        .enable  (state_q == ACCESS),
        .expired (expired)
    );

    assign slot_in       = addr_i[SEL_LSB +: 4];
    assign slot_in_range = ({1'b0, slot_in} < 5'(NUM_SLAVES));

    // Slot decode by comparison keeps the 4-bit slot index independent of
    // how many slots are actually built.
    always_comb begin
        onehot_in = '0;
        ack_sel   = 1'b0;
        rd_sel    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot_in == 4'(k)) begin
                onehot_in[k] = 1'b1;
            end
            if (slot_q == 4'(k)) begin
                ack_sel = s_ack_i[k];
                rd_sel  = s_data_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            cyc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        ack_d      = 1'b0;
        data_d     = data_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_addr_d = err_addr_q;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i && addr_i[31]) begin
                    slot_d  = slot_in;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    if (slot_in_range) begin
                        cyc_d   = onehot_in;
                        state_d = ACCESS;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ACCESS: begin
                // An abandoned cycle is dropped silently; a real ack beats
                // the watchdog when both land together.
                if (!cyc_i) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                end else if (ack_sel) begin
                    cyc_d   = '0;
                    ack_d   = 1'b1;
                    data_d  = we_q ? 32'h0 : rd_sel;
                    state_d = RESP;
                end else if (expired) begin
                    cyc_d      = '0;
                    ack_d      = 1'b1;
                    data_d     = ERR_DATA;
                    err_set    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = RESP;
                end
            end
            ERROR: begin
                ack_d      = 1'b1;
                data_d     = ERR_DATA;
                err_set    = 1'b1;
                err_addr_d = addr_q;
                state_d    = RESP;
            end
            RESP: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign ack_o      = ack_q;
    assign data_o     = data_q;
    assign s_cyc_o    = cyc_q;
    assign s_stb_o    = cyc_q;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_data_o   = wdata_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_wb_periph_bridge.sv
// Self-checking bench for wb_periph_bridge (4 slots, 8-cycle timeout).
// Stimulus tasks push the expected core response into a scoreboard queue; a
// negedge monitor pops and compares whenever ack_o is seen.
module tb_wb_periph_bridge;

    localparam int          NS = 4;
    localparam int          TO = 8;
    localparam logic [31:0] ED = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [31:0]      addr_i = '0, data_i = '0;
    logic             ack_o;
    logic [31:0]      data_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic             s_we_o;
    logic [31:0]      s_addr_o, s_data_o;
    logic [NS-1:0]    s_ack_i = '0;
    logic [NS*32-1:0] s_data_i = '0;
    logic             err_clr_i = 1'b0;
    logic             err_o;
    logic [31:0]      err_addr_o;

    always #5 clk = ~clk;

    wb_periph_bridge #(
        .NUM_SLAVES     (NS),
        .SEL_LSB        (24),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .data_o     (data_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_ack_i    (s_ack_i),
        .s_data_i   (s_data_i),
        .err_clr_i  (err_clr_i),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    bit          model_err = 1'b0;
    logic [31:0] model_eaddr = '0;
    int          exp_strobes = 0;
    int          seen_strobes = 0;
    bit          clr_race = 1'b0;
    bit          prev_ack = 1'b0;
    logic [NS-1:0] prev_cyc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
            prev_cyc = '0;
        end else begin
            chk("ack_back_to_back", {31'b0, ack_o & prev_ack}, 32'h0);
            if (ack_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack_o=1 expected no response pending");
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_data", data_o, mon_e.data);
                    chk("resp_err", {31'b0, err_o}, {31'b0, mon_e.err});
                    chk("resp_err_addr", err_addr_o, mon_e.eaddr);
                end
            end
            if (s_cyc_o != '0 && prev_cyc == '0) seen_strobes++;
            prev_ack = ack_o;
            prev_cyc = s_cyc_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One core transaction. d = strobe cycles the slave waits before acking
    // (ack during strobe cycle d+1); noack = slave stays silent.
    task automatic txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                       input int d, input logic [31:0] rdata, input bit noack);
        int            slot;
        bit            mapped, fail;
        logic [NS-1:0] onehot;
        exp_t          e;
        int            c, sc, ack_c;
        bit            got;
        slot   = int'(addr[27:24]);
        mapped = (slot < NS);
        fail   = !mapped || noack;
        onehot = '0;
        if (mapped) onehot[slot] = 1'b1;
        if (fail) begin
            model_err   = 1'b1;
            model_eaddr = addr;
        end
        e.data  = fail ? ED : (we ? 32'h0 : rdata);
        e.err   = model_err;
        e.eaddr = model_eaddr;
        sb.push_back(e);
        if (mapped) exp_strobes++;

        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = addr; data_i = wdata;
        c = 0; sc = 0; ack_c = 0; got = 1'b0;
        while (!got && c < 40) begin
            step();
            c++;
            s_ack_i   = '0;
            err_clr_i = (clr_race && c == 1);
            for (int k = 0; k < NS; k++) s_data_i[32*k +: 32] = $urandom;
            if (mapped) s_data_i[slot*32 +: 32] = rdata;
            if (s_cyc_o != '0) begin
                sc++;
                chk("s_cyc_onehot", 32'(s_cyc_o), 32'(onehot));
                chk("s_stb_onehot", 32'(s_stb_o), 32'(onehot));
                if (sc == 1) begin
                    chk("s_addr", s_addr_o, addr);
                    chk("s_we", {31'b0, s_we_o}, {31'b0, we});
                    chk("s_data", s_data_o, wdata);
                end
                s_ack_i = NS'($urandom) & ~onehot;
                if (!noack && sc == d + 1) s_ack_i = s_ack_i | onehot;
            end
            if (ack_o) begin
                got   = 1'b1;
                ack_c = c;
            end
        end
        s_ack_i   = '0;
        err_clr_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: got no ack_o within 40 cycles expected ack for addr %h", addr);
        end
        chk("ack_latency", ack_c, !mapped ? 2 : (noack ? TO + 1 : d + 2));
        chk("strobe_cycles", sc, !mapped ? 0 : (noack ? TO : d + 1));
        // core keeps cyc_i up one cycle past the ack
        step();
        step();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        chk("no_reissue", 32'(s_cyc_o), 32'h0);
        step();
    endtask

    initial begin
        logic [31:0] a;
        int          slot;

        repeat (3) step();
        chk("rst_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_addr", s_addr_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_err_addr", err_addr_o, 32'h0);
        rst_n = 1'b1;
        step();

        // addr[31]=0 must be ignored
        cyc_i = 1'b1; stb_i = 1'b1; addr_i = 32'h0100_0000;
        repeat (4) begin
            step();
            chk("ignore_cyc", 32'(s_cyc_o), 32'h0);
            chk("ignore_ack", {31'b0, ack_o}, 32'h0);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        step();

        txn(32'h8100_0004, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0);
        txn(32'h8000_0010, 1'b1, 32'hA5A5_A5A5, 1, 32'h0BAD_0BAD, 1'b0);
        txn(32'h8700_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        txn(32'h8200_0000, 1'b0, 32'h0, 0, 32'h0, 1'b1);
        chk("err_before_clr", {31'b0, err_o}, 32'h1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        model_err = 1'b0;
        chk("err_after_clr", {31'b0, err_o}, 32'h0);
        chk("err_addr_kept", err_addr_o, model_eaddr);
        // ack on the last permitted cycle beats the timeout
        txn(32'h8300_0040, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
        // error set and clear in the same cycle: set wins
        clr_race = 1'b1;
        txn(32'h8500_0008, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        clr_race = 1'b0;

        for (int i = 0; i < 40; i++) begin
            slot = $urandom_range(0, 7);
            a = {1'b1, 3'($urandom), 4'(slot), 24'($urandom)};
            txn(a, 1'($urandom), $urandom, $urandom_range(0, 6), $urandom,
                ($urandom_range(0, 9) == 0));
        end

        // abort mid-ACCESS
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'h8200_0100;
        exp_strobes++;
        repeat (3) step();
        chk("abort_strobe_on", 32'(s_cyc_o), 32'h4);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        chk("abort_strobe_off", 32'(s_cyc_o), 32'h0);
        repeat (4) begin
            step();
            chk("abort_no_ack", {31'b0, ack_o}, 32'h0);
        end
        chk("abort_err", {31'b0, err_o}, {31'b0, model_err});

        // leave err_o/data_o non-zero, then reset mid-ACCESS
        txn(32'h8600_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 32'h8300_0020; data_i = 32'h5555_AAAA;
        exp_strobes++;
        repeat (3) step();
        chk("mid_strobe_on", 32'(s_cyc_o), 32'h8);
        rst_n = 1'b0;
        step();
        chk("mrst_ack", {31'b0, ack_o}, 32'h0);
        chk("mrst_data", data_o, 32'h0);
        chk("mrst_cyc", 32'(s_cyc_o), 32'h0);
        chk("mrst_stb", 32'(s_stb_o), 32'h0);
        chk("mrst_we", {31'b0, s_we_o}, 32'h0);
        chk("mrst_saddr", s_addr_o, 32'h0);
        chk("mrst_sdata", s_data_o, 32'h0);
        chk("mrst_err", {31'b0, err_o}, 32'h0);
        chk("mrst_err_addr", err_addr_o, 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        model_err = 1'b0;
        model_eaddr = '0;
        step();
        rst_n = 1'b1;
        step();
        txn(32'h8100_0000, 1'b0, 32'h0, 3, 32'h7777_0001, 1'b0);

        repeat (3) step();
        chk("strobe_count", seen_strobes, exp_strobes);
        chk("pending_responses", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
